// File: rtl/pc_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_pkg
// Shared definitions for the IF-stage fetch controller:
//   fetch_state_e     - fetch FSM states
//   RESET_PC_DEFAULT  - boot vector loaded into the PC at reset
//   NOP_INSTR         - instruction word presented when nothing was fetched
// ---------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_CANCEL = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_pc_next_sel
// Combinational next-PC priority mux: a redirect resolved this cycle wins,
// then a redirect remembered from an earlier cycle, then sequential pc+4.
// Ports:
//   pc_i               current PC
//   redirect_valid_i   redirect resolved by ID this cycle
//   redirect_target_i  its target
//   pending_valid_i    remembered redirect present
//   pending_target_i   remembered target
//   next_pc_o          selected next PC
// ---------------------------------------------------------------------------
module pc_fetch_ctrl_pc_next_sel #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_target_i,
    input  logic              pending_valid_i,
    input  logic [ADDR_W-1:0] pending_target_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_i + ADDR_W'(4);   // wraps modulo 2^ADDR_W
        if (redirect_valid_i) begin
            next_pc_o = redirect_target_i;
        end else if (pending_valid_i) begin
            next_pc_o = pending_target_i;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// IF-stage PC and instruction-fetch controller. Issues one SRAM-like fetch
// at a time, holds the fetched word and its PC for ID, applies ID redirects
// after the delay slot, and squashes everything on an exception flush.
// Optional build macro: PC_ALIGN_CHECK_EN adds fetch_adel (misaligned fetch
// PC flagged instead of requested).
// Ports:
//   clk, resetn                    clock, async active-low reset
//   stall_f                        hold the current instruction
//   redirect_valid/_target         branch taken / jump from ID
//   flush, flush_pc                exception/eret redirect
//   inst_req, inst_addr            fetch request
//   inst_addr_ok, inst_data_ok     request accepted / data returned
//   inst_rdata                     returned instruction
//   instr_f, pc_f, pc_plus8_f      held instruction, its PC, link address
//   fetch_valid                    instr_f valid for ID
//   fetch_adel                     (PC_ALIGN_CHECK_EN) fetch address error
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall_f,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic [31:0]       instr_f,
    output logic [ADDR_W-1:0] pc_f,
`ifdef PC_ALIGN_CHECK_EN
    output logic              fetch_adel,
`endif
    output logic [ADDR_W-1:0] pc_plus8_f,
    output logic              fetch_valid
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              fvalid_q;
    logic              pend_valid_q;
    logic [ADDR_W-1:0] pend_target_q;
    logic [ADDR_W-1:0] next_pc_d;
    logic              pc_adv;
    logic              req_issue;

    pc_fetch_ctrl_pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
        .pc_i              (pc_q),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .pending_valid_i   (pend_valid_q),
        .pending_target_i  (pend_target_q),
        .next_pc_o         (next_pc_d)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q;
    logic misalign;
    assign misalign   = |pc_q[1:0];
    assign fetch_adel = adel_q;
    assign req_issue  = (state_q == S_REQ) && !misalign;
`else
    assign req_issue  = (state_q == S_REQ);
`endif

    // The PC moves only when an instruction is handed to ID and not stalled.
    assign pc_adv = !flush && !stall_f &&
                    (((state_q == S_WAIT) && inst_data_ok) || (state_q == S_HOLD));

    assign inst_req    = req_issue;
    assign inst_addr   = pc_q;
    assign instr_f     = instr_q;
    assign pc_f        = pc_q;
    assign fetch_valid = fvalid_q;
    assign pc_plus8_f  = pc_q + ADDR_W'(8);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            fvalid_q      <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
`ifdef PC_ALIGN_CHECK_EN
            adel_q        <= 1'b0;
`endif
        end else begin
            // A redirect that cannot be applied now (PC not advancing) is
            // remembered until the delay slot is handed over; last one wins.
            if (flush || pc_adv) begin
                pend_valid_q <= 1'b0;
            end else if (redirect_valid) begin
                pend_valid_q  <= 1'b1;
                pend_target_q <= redirect_target;
            end

            if (flush) begin
                pc_q     <= flush_pc;
                fvalid_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                adel_q   <= 1'b0;
`endif
                // An accepted but unreturned request must be drained in CANCEL.
                unique case (state_q)
                    S_REQ:    state_q <= (req_issue && inst_addr_ok) ? S_CANCEL : S_REQ;
                    S_WAIT:   state_q <= inst_data_ok ? S_REQ : S_CANCEL;
                    S_CANCEL: state_q <= inst_data_ok ? S_REQ : S_CANCEL;
                    default:  state_q <= S_REQ;
                endcase
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_REQ;
                    end
                    S_REQ: begin
`ifdef PC_ALIGN_CHECK_EN
                        if (misalign) begin
                            instr_q  <= NOP_INSTR;
                            fvalid_q <= 1'b1;
                            adel_q   <= 1'b1;
                            state_q  <= S_HOLD;
                        end else
`endif
                        begin
                            fvalid_q <= 1'b0;
                            if (inst_addr_ok) begin
                                state_q <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (inst_data_ok) begin
                            instr_q  <= inst_rdata;
                            fvalid_q <= 1'b1;
                            if (!stall_f) begin
                                pc_q    <= next_pc_d;
                                state_q <= S_REQ;
                            end else begin
                                state_q <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall_f) begin
                            pc_q     <= next_pc_d;
                            fvalid_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                            adel_q   <= 1'b0;
`endif
                            state_q  <= S_REQ;
                        end
                    end
                    S_CANCEL: begin
                        if (inst_data_ok) begin
                            state_q <= S_REQ;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- IF-stage program-counter and instruction-fetch controller. Directly upstream of the ID-stage branch comparator.
- Drives the instruction SRAM-like request/handshake and holds the fetched instruction plus its PC for ID.
- Applies branch/jump redirects that ID resolves, honouring the MIPS delay slot: the in-flight or held IF instruction is always the delay slot and is never squashed by a redirect.
- Applies exception flushes, which squash everything in flight.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded at reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- stall_f  in  1  IF stall from the hazard unit; hold the current instruction.
- redirect_valid  in  1  ID branch taken (comparator result AND branch instruction) or jump.
- redirect_target  in  ADDR_W  branch/jump target.
- flush  in  1  exception/eret flush.
- flush_pc  in  ADDR_W  exception vector or EPC.
- inst_req  out  1  fetch request.
- inst_addr  out  ADDR_W  fetch address.
- inst_addr_ok  in  1  request accepted.
- inst_data_ok  in  1  read data returned.
- inst_rdata  in  32  read data.
- instr_f  out  32  held instruction.
- pc_f  out  ADDR_W  PC of instr_f / current fetch.
- pc_plus8_f  out  ADDR_W  pc_f+8; link address for BLTZAL/BGEZAL/JAL.
- fetch_valid  out  1  instr_f valid for ID.

Behaviour:
- Reset (async, resetn=0):
  - pc_f=RESET_PC, inst_req=0, instr_f=0, fetch_valid=0.
  - pending_valid=0, pending_target=0, state=IDLE.
- States:
  - IDLE → REQ unconditionally on the first clock after reset release.
  - REQ: inst_req=1, inst_addr=pc_f.
    - addr_ok → WAIT.
    - Address held stable until addr_ok, except on flush.
  - WAIT: inst_req=0.
    - data_ok with stall_f=0: instr_f<=inst_rdata, fetch_valid<=1, pc_f<=next_pc, → REQ.
    - data_ok with stall_f=1: capture instr_f, fetch_valid<=1, → HOLD.
  - HOLD: instr_f and pc_f frozen.
    - When stall_f=0: pc_f<=next_pc, fetch_valid<=0, → REQ.
  - CANCEL: wait for data_ok, discard the data, → REQ.
- fetch_valid: in the REQ cycle following a consume, fetch_valid=0. ID sees a 1-cycle bubble per fetch minimum. No prefetch.
- next_pc priority:
  - redirect_valid → redirect_target.
  - else pending_valid → pending_target.
  - else pc_f+4 (mod 2^32; 32'hFFFF_FFFC+4 wraps to 0).
- Pending redirect:
  - redirect_valid in a cycle where pc_f does not advance → pending_target<=redirect_target, pending_valid<=1.
  - Cleared when pc_f advances.
  - A second redirect while pending overwrites it (last wins).
- Flush (highest priority; overrides stall_f and redirect):
  - pc_f<=flush_pc, fetch_valid<=0, pending cleared.
  - From REQ without addr_ok, HOLD, or IDLE → REQ.
  - From REQ with addr_ok same cycle, or from WAIT without data_ok → CANCEL.
  - From WAIT with data_ok same cycle → data dropped, → REQ.
  - From CANCEL: pc_f updated, stay CANCEL.
- pc_plus8_f: combinational, pc_f+8, wraps.
- Reset mid-transaction: immediate return to reset values. The SRAM side must also be reset; any late data_ok in IDLE is ignored.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Enabled: adds output fetch_adel (1 bit, reset 0).
  - If pc_f[1:0]!=0 when entering REQ, no request is issued.
  - State goes to HOLD with instr_f=0, fetch_valid=1, fetch_adel=1.
  - fetch_adel clears when the instruction is consumed or on flush.
- Disabled: no port; inst_addr driven with pc_f unchecked.

Decomposition:
- Shared package:
  - fetch state enum (IDLE, REQ, WAIT, HOLD, CANCEL).
  - RESET_PC default constant.
  - NOP instruction constant (32'h0).
- One natural sub-module: pc_next_sel, the combinational next_pc priority mux (redirect/pending/+4).
- Flush is handled in the parent.

Test Plan:
- Reset release with addr_ok/data_ok 1 cycle each → inst_addr sequence BFC0_0000, BFC0_0004, BFC0_0008; fetch_valid pulses; pc_plus8_f=BFC0_0008 while pc_f=BFC0_0000.
- Branch at BFC0_0010 resolves in ID (redirect_valid=1, target BFC0_0100) while delay slot BFC0_0014 is in WAIT → delay slot delivered, next inst_addr=BFC0_0100.
- stall_f=1 for 3 cycles in HOLD with redirect to 8000_0040 in the first stall cycle → pending latched; after the stall drops, next inst_addr=8000_0040 and pending clears.
- flush=1, flush_pc=BFC0_0380 while in WAIT, data_ok 2 cycles later → returned data discarded, fetch_valid stays 0, next inst_addr=BFC0_0380.
- flush and data_ok in the same WAIT cycle with stall_f=1 → data dropped, REQ to flush_pc, no HOLD entry.
- PC_ALIGN_CHECK_EN, redirect to 0000_0102 → no inst_req for that address; fetch_adel=1, fetch_valid=1, instr_f=0.
